// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES key schedule, one 32-bit word per clock through 4 shared S-boxes
// Build option AES_KEYEXP_ZEROIZE_EN: clears w[NK..] at key load so stale words from a previous key never show
// Ports: clk, reset (async, active-high), start, key[32*NK] -> busy, done (1-cycle pulse), keys_valid, ExpandedKeys[128*(NR+1)]
module aes_key_expander #(
   parameter int NR = 10,
   parameter int NK = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [32*NK-1:0]        key,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic [128*(NR+1)-1:0]   ExpandedKeys
);
   localparam int NW = 4 * (NR + 1);
   localparam int IW = $clog2(NW);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   typedef enum logic {IDLE, EXPAND} state_t;
   state_t state;
   logic [31:0] w [NW];
   logic [IW-1:0] i;
   logic [3:0] kmod;
   logic [7:0] rcon;
   logic [31:0] prev, sub_in, sub, temp, w_new;
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8 * int'(x) -: 8];
   endfunction
   always_comb begin
      prev   = w[i - IW'(1)];
      sub_in = kmod == 4'd0 ? {prev[23:0], prev[31:24]} : prev;
      sub    = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
      temp   = kmod == 4'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && kmod == 4'd4) ? sub : prev;
      w_new  = w[i - IW'(NK)] ^ temp;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         i          <= '0;
         kmod       <= '0;
         rcon       <= 8'h01;
         busy       <= 1'b0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         for (int j = 0; j < NW; j++) w[j] <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               for (int j = 0; j < NK; j++) w[j] <= key[32*NK-1-32*j -: 32];
`ifdef AES_KEYEXP_ZEROIZE_EN
               for (int j = NK; j < NW; j++) w[j] <= '0;
`endif
               i          <= IW'(NK);
               kmod       <= '0;
               rcon       <= 8'h01;
               busy       <= 1'b1;
               keys_valid <= 1'b0;
               state      <= EXPAND;
            end
         end else begin
            w[i] <= w_new;
            i    <= i + 1'b1;
            kmod <= kmod == 4'(NK - 1) ? 4'd0 : kmod + 4'd1;
            if (kmod == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (i == IW'(NW - 1)) begin
               busy       <= 1'b0;
               done       <= 1'b1;
               keys_valid <= 1'b1;
               state      <= IDLE;
            end
         end
      end
   end
   for (genvar g = 0; g < NW; g++) begin : g_out
      assign ExpandedKeys[128*(NR+1)-1-32*g -: 32] = w[g];
   end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed FIPS-197 vectors for AES-128/192/256 key schedules plus restart/reset sequences
module tb_aes_key_expander;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic [2:0] start = '0;
   logic [2:0] busy, done, kv;
   logic [127:0] key128 = '0;
   logic [191:0] key192 = '0;
   logic [255:0] key256 = '0;
   logic [1407:0] ek128;
   logic [1663:0] ek192;
   logic [1919:0] ek256;
   int passed = 0;
   int total = 0;
   typedef struct {
      int          ph;
      int          s;
      int          j;
      logic [31:0] w;
   } vec_t;
   vec_t vt [25];
   aes_key_expander #(.NR(10), .NK(4)) dut128 (.clk(clk), .reset(reset), .start(start[0]), .key(key128),
      .busy(busy[0]), .done(done[0]), .keys_valid(kv[0]), .ExpandedKeys(ek128));
   aes_key_expander #(.NR(12), .NK(6)) dut192 (.clk(clk), .reset(reset), .start(start[1]), .key(key192),
      .busy(busy[1]), .done(done[1]), .keys_valid(kv[1]), .ExpandedKeys(ek192));
   aes_key_expander #(.NR(14), .NK(8)) dut256 (.clk(clk), .reset(reset), .start(start[2]), .key(key256),
      .busy(busy[2]), .done(done[2]), .keys_valid(kv[2]), .ExpandedKeys(ek256));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   function automatic logic [31:0] word(input int s, input int j);
      case (s)
         0: return ek128[1407-32*j -: 32];
         1: return ek192[1663-32*j -: 32];
         default: return ek256[1919-32*j -: 32];
      endcase
   endfunction
   task automatic run(input int s, input int lat, input logic [31:0] w4_after, input bit poke);
      int n;
      bit kv_early;
      @(negedge clk) start[s] = 1'b1;
      @(posedge clk);
      #1 start[s] = 1'b0;
      n = 0;
      kv_early = 1'b0;
      check($sformatf("busy_E0_%0d", s), busy[s], 1);
      check($sformatf("kv_E0_%0d", s), kv[s], 0);
      if (s == 0) check("w4_after_E0", word(0, 4), w4_after);
      while (!done[s] && n < 100) begin
         if (poke && n == 5) begin
            start[s] = 1'b1;
            key128 = ~key128;
         end else start[s] = 1'b0;
         @(posedge clk);
         #1 n++;
         if (kv[s] && !done[s]) kv_early = 1'b1;
      end
      start[s] = 1'b0;
      check($sformatf("done_latency_%0d", s), n, lat);
      check($sformatf("kv_at_done_%0d", s), kv[s], 1);
      check($sformatf("busy_at_done_%0d", s), busy[s], 0);
      check($sformatf("kv_early_%0d", s), kv_early, 0);
      @(posedge clk);
      #1 check($sformatf("done_width_%0d", s), done[s], 0);
      check($sformatf("kv_hold_%0d", s), kv[s], 1);
   endtask
   task automatic check_table(input int ph);
      for (int k = 0; k < 25; k++)
         if (vt[k].ph == ph)
            check($sformatf("w%0d[%0d]", vt[k].s, vt[k].j), word(vt[k].s, vt[k].j), vt[k].w);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      vt = '{
         '{0, 0, 0, 32'h2b7e1516}, '{0, 0, 4, 32'ha0fafe17}, '{0, 0, 5, 32'h88542cb1},
         '{0, 0, 40, 32'hd014f9a8}, '{0, 0, 41, 32'hc9ee2589}, '{0, 0, 42, 32'he13f0cc8},
         '{0, 0, 43, 32'hb6630ca6},
         '{0, 1, 5, 32'h522c6b7b}, '{0, 1, 6, 32'hfe0c91f7}, '{0, 1, 48, 32'he98ba06f},
         '{0, 1, 49, 32'h448c773c}, '{0, 1, 50, 32'h8ecc7204}, '{0, 1, 51, 32'h01002202},
         '{0, 2, 7, 32'h0914dff4}, '{0, 2, 8, 32'h9ba35411}, '{0, 2, 56, 32'hfe4890d1},
         '{0, 2, 57, 32'he6188d0b}, '{0, 2, 58, 32'h046df344}, '{0, 2, 59, 32'h706c631e},
         '{1, 0, 0, 32'h00010203}, '{1, 0, 4, 32'hd6aa74fd}, '{1, 0, 40, 32'h13111d7f},
         '{1, 0, 41, 32'he3944a17}, '{1, 0, 42, 32'hf307a78b}, '{1, 0, 43, 32'h4d2b30c5}};
      #12;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst_busy_%0d", s), busy[s], 0);
         check($sformatf("rst_done_%0d", s), done[s], 0);
         check($sformatf("rst_kv_%0d", s), kv[s], 0);
      end
      check("rst_ek", {29'd0, |ek128, |ek192, |ek256}, 0);
      @(negedge clk) reset = 1'b0;
      key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      run(0, 40, 32'h0, 1'b1);
      run(1, 46, 32'h0, 1'b0);
      run(2, 52, 32'h0, 1'b0);
      check_table(0);
      key128 = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_KEYEXP_ZEROIZE_EN
      run(0, 40, 32'h0, 1'b0);
`else
      run(0, 40, 32'ha0fafe17, 1'b0);
`endif
      check_table(1);
      @(negedge clk) start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (20) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midrst_busy", busy[0], 0);
      check("midrst_done", done[0], 0);
      check("midrst_kv", kv[0], 0);
      check("midrst_ek", {31'd0, |ek128}, 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("postrst_busy", busy[0], 0);
      check("postrst_kv", kv[0], 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
